// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core types for the hazard controller.
// State encoding and architectural register constants.
package core_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT,
    TIMEOUT_FLUSH
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use detector: EX holds a load whose Rd
// feeds a source actually read by the ID instruction.
module load_use_detect
  import core_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic hit1;
  logic hit2;

  assign hit1 = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign hit2 = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  assign load_use_o = ex_mem_read_i
                   && (ex_rd_i != REG_ZERO)
                   && (hit1 || hit2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: stall/flush generation,
// redirect bubble sequencing, memory-wait timeout.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs1,
  input  logic [4:0]  ID_Rs2,
  input  logic        ID_UsesRs1,
  input  logic        ID_UsesRs2,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        ID_EX_MemRead,
  input  logic        EX_Redirect,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        IF_ID_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        hazard_stall,
  output logic        hazard_flush,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cycles
);

  localparam logic [2:0] RB    = 3'(REDIRECT_BUBBLES);
  localparam logic [2:0] RB_M1 = RB - 3'd1;
  localparam logic [7:0] TO_M1 = 8'(MEM_TIMEOUT) - 8'd1;

  hz_state_t   state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [2:0]  bub_q, bub_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;
  logic [31:0] scnt_q, scnt_d;

  logic mem_wait;
  logic load_use;
  logic pc_st_c, ifid_st_c, ifid_fl_c;
  logic idex_fl_c, hz_st_c, hz_fl_c;

  load_use_detect u_lu (
    .id_rs1_i      (ID_Rs1),
    .id_rs2_i      (ID_Rs2),
    .id_uses_rs1_i (ID_UsesRs1),
    .id_uses_rs2_i (ID_UsesRs2),
    .ex_rd_i       (ID_EX_Rd),
    .ex_mem_read_i (ID_EX_MemRead),
    .load_use_o    (load_use)
  );

  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bub_d     = bub_q;
    pend_d    = pend_q;
    err_d     = err_q;
    pc_st_c   = 1'b0;
    ifid_st_c = 1'b0;
    ifid_fl_c = 1'b0;
    idex_fl_c = 1'b0;
    hz_st_c   = 1'b0;
    hz_fl_c   = 1'b0;

    if (state_q == TIMEOUT_FLUSH) begin
      hz_fl_c   = 1'b1;
      ifid_fl_c = 1'b1;
      idex_fl_c = 1'b1;
      state_d   = RUN;
      wait_d    = '0;
      pend_d    = 1'b0;
    end else if (mem_wait) begin
      pc_st_c   = 1'b1;
      ifid_st_c = 1'b1;
      hz_st_c   = 1'b1;
      state_d   = MEM_WAIT;
      wait_d    = wait_q + 8'd1;
      // an interrupted bubble train restarts after the wait
      if (EX_Redirect || state_q == REDIRECT)
        pend_d = 1'b1;
      if (wait_q >= TO_M1) begin
        state_d = TIMEOUT_FLUSH;
        err_d   = 1'b1;
        pend_d  = 1'b0;
        wait_d  = '0;
      end
    end else if (state_q == MEM_WAIT) begin
      wait_d = '0;
      pend_d = 1'b0;
      if (pend_q || EX_Redirect) begin
        state_d = REDIRECT;
        bub_d   = RB;
      end else begin
        state_d = RUN;
        if (load_use) begin
          pc_st_c   = 1'b1;
          ifid_st_c = 1'b1;
          idex_fl_c = 1'b1;
        end
      end
    end else if (state_q == REDIRECT || EX_Redirect) begin
      ifid_fl_c = 1'b1;
      idex_fl_c = 1'b1;
      if (EX_Redirect) begin
        bub_d   = RB_M1;
        state_d = (RB > 3'd1) ? REDIRECT : RUN;
      end else begin
        bub_d   = bub_q - 3'd1;
        state_d = (bub_q <= 3'd1) ? RUN : REDIRECT;
      end
    end else if (load_use) begin
      pc_st_c   = 1'b1;
      ifid_st_c = 1'b1;
      idex_fl_c = 1'b1;
    end
  end

  assign pc_stall     = !reset && pc_st_c;
  assign IF_ID_stall  = !reset && ifid_st_c;
  assign IF_ID_flush  = !reset && ifid_fl_c;
  assign ID_EX_flush  = !reset && idex_fl_c;
  assign hazard_stall = !reset && hz_st_c;
  assign hazard_flush = !reset && hz_fl_c;

  assign scnt_d = (pc_stall && scnt_q != 32'hFFFF_FFFF)
                ? scnt_q + 32'd1 : scnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      bub_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bub_q   <= bub_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      scnt_q  <= scnt_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_cycles    = scnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl.
// Two instances: long timeout, and MEM_TIMEOUT=3.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_Rs1, ID_Rs2, ID_EX_Rd;
  logic        ID_UsesRs1, ID_UsesRs2;
  logic        ID_EX_MemRead, EX_Redirect;
  logic        dmem_req, dmem_ready;

  logic        a_pcs, a_ifs, a_iff, a_idf;
  logic        a_hs, a_hf, a_err;
  logic [31:0] a_sc;
  logic        b_pcs, b_ifs, b_iff, b_idf;
  logic        b_hs, b_hf, b_err;
  logic [31:0] b_sc;

  int errors = 0;
  int checks = 0;

  logic [38:0] exp_q[$];
  bit          sel_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REDIRECT_BUBBLES(2), .MEM_TIMEOUT(255)
  ) dut_a (
    .clk(clk), .reset(reset),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_Redirect(EX_Redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(a_pcs), .IF_ID_stall(a_ifs),
    .IF_ID_flush(a_iff), .ID_EX_flush(a_idf),
    .hazard_stall(a_hs), .hazard_flush(a_hf),
    .mem_timeout_err(a_err), .stall_cycles(a_sc)
  );

  pipeline_hazard_ctrl #(
    .REDIRECT_BUBBLES(2), .MEM_TIMEOUT(3)
  ) dut_b (
    .clk(clk), .reset(reset),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_Redirect(EX_Redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(b_pcs), .IF_ID_stall(b_ifs),
    .IF_ID_flush(b_iff), .ID_EX_flush(b_idf),
    .hazard_stall(b_hs), .hazard_flush(b_hf),
    .mem_timeout_err(b_err), .stall_cycles(b_sc)
  );

  // {pcs,ifs,iff,idf,hs,hf,err} : 7'b pattern
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1101000;
  localparam logic [6:0] RDR  = 7'b0011000;
  localparam logic [6:0] MW   = 7'b1100100;
  localparam logic [6:0] TOF  = 7'b0011011;
  localparam logic [6:0] ERR  = 7'b0000001;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [38:0] e, g;
      bit s;
      string n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      g = s ? {b_pcs, b_ifs, b_iff, b_idf, b_hs, b_hf, b_err, b_sc}
            : {a_pcs, a_ifs, a_iff, a_idf, a_hs, a_hf, a_err, a_sc};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b cnt=%0d want flags=%b cnt=%0d",
                 n, g[38:32], g[31:0], e[38:32], e[31:0]);
      end
    end
  end

  task automatic cyc(input string nm, input bit s,
                     input logic [6:0] f, input int sc);
    exp_q.push_back({f, 32'(sc)});
    sel_q.push_back(s);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ID_Rs1 = 0; ID_Rs2 = 0; ID_EX_Rd = 0;
    ID_UsesRs1 = 0; ID_UsesRs2 = 0;
    ID_EX_MemRead = 0; EX_Redirect = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    tick();
    cyc("reset_state", 0, IDLE, 0);
    reset = 1'b0;
    cyc("idle", 0, IDLE, 0);

    ID_EX_MemRead = 1; ID_EX_Rd = 5; ID_Rs1 = 5; ID_UsesRs1 = 1;
    cyc("lu_rs1", 0, LU, 0);
    clr();
    cyc("lu_after", 0, IDLE, 1);
    ID_EX_MemRead = 1; ID_EX_Rd = 0; ID_Rs1 = 0; ID_UsesRs1 = 1;
    cyc("lu_rd0", 0, IDLE, 1);
    clr();
    ID_EX_MemRead = 1; ID_EX_Rd = 7; ID_Rs2 = 7;
    cyc("lu_rs2_unused", 0, IDLE, 1);
    ID_UsesRs2 = 1;
    cyc("lu_rs2", 0, LU, 1);
    clr();
    cyc("lu2_after", 0, IDLE, 2);

    EX_Redirect = 1;
    cyc("rdr_c0", 0, RDR, 2);
    EX_Redirect = 0;
    cyc("rdr_c1", 0, RDR, 2);
    cyc("rdr_done", 0, IDLE, 2);

    EX_Redirect = 1;
    ID_EX_MemRead = 1; ID_EX_Rd = 3; ID_Rs1 = 3; ID_UsesRs1 = 1;
    cyc("rdr_lu_c0", 0, RDR, 2);
    clr();
    cyc("rdr_lu_c1", 0, RDR, 2);
    cyc("rdr_lu_done", 0, IDLE, 2);

    dmem_req = 1;
    for (int i = 0; i < 4; i++) cyc("mw", 0, MW, 2 + i);
    dmem_ready = 1;
    cyc("mw_exit", 0, IDLE, 6);
    clr();
    cyc("mw_idle", 0, IDLE, 6);

    dmem_req = 1;
    cyc("mwr_w1", 0, MW, 6);
    EX_Redirect = 1;
    cyc("mwr_w2", 0, MW, 7);
    EX_Redirect = 0;
    cyc("mwr_w3", 0, MW, 8);
    dmem_ready = 1;
    cyc("mwr_exit", 0, IDLE, 9);
    clr();
    cyc("mwr_b1", 0, RDR, 9);
    cyc("mwr_b2", 0, RDR, 9);
    cyc("mwr_done", 0, IDLE, 9);

    dmem_req = 1; EX_Redirect = 1;
    cyc("rst_w1", 0, MW, 9);
    EX_Redirect = 0;
    cyc("rst_w2", 0, MW, 10);
    reset = 1;
    cyc("rst_hi", 0, IDLE, 11);
    reset = 0;
    clr();
    cyc("rst_after", 0, IDLE, 0);
    cyc("rst_noflush1", 0, IDLE, 0);
    cyc("rst_noflush2", 0, IDLE, 0);

    reset = 1;
    tick();
    cyc("b_reset", 1, IDLE, 0);
    reset = 0;
    dmem_req = 1;
    for (int i = 0; i < 3; i++) cyc("to_wait", 1, MW, i);
    cyc("to_flush", 1, TOF, 3);
    clr();
    cyc("to_sticky1", 1, ERR, 3);
    cyc("to_sticky2", 1, ERR, 3);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
